// File: rtl/cga_lut_pkg.sv
// ============================================================================
// Module   : cga_lut_pkg
// Brief    : Shared types and constants for the CGA composite LUT arbiter.
//            Optional host readback is enabled by macro CGA_LUT_HOST_RD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cga_lut_pkg;

    // Default geometry of the pattern LUT and starvation threshold
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 18;
    localparam int DEF_STALL_MAX = 15;

    // Request-to-data latencies seen by video and host readers
    localparam int VID_LAT     = 2;
    localparam int HOST_RD_LAT = 2;

    // Arbiter state; the read-path states exist only when readback is built in
`ifdef CGA_LUT_HOST_RD_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_CAP  = 2'd2,
        ACK     = 2'd3
    } lut_state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd3
    } lut_state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/cga_lut_stall_mon.sv
// ============================================================================
// Module   : cga_lut_stall_mon
// Brief    : Saturating count of host cycles denied by video, with a sticky
//            starvation flag raised when the count reaches STALL_MAX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cga_lut_stall_mon
    import cga_lut_pkg::*;
#(
    parameter int STALL_MAX = DEF_STALL_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_stall_err
);

    localparam int                 c_CNT_W = $clog2(STALL_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(STALL_MAX);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_stall_err;

    // Next count: clear on grant, otherwise step towards the saturation point
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc && (r_cnt != c_MAX)) begin
            w_cnt_nxt = r_cnt + c_ONE;
        end
    end

    // Counter register and sticky flag that only reset can clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == c_MAX) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    assign o_stall_err = r_stall_err;

endmodule

`default_nettype wire

// File: rtl/cga_lut_arbiter.sv
// ============================================================================
// Module   : cga_lut_arbiter
// Brief    : Shares a single-port synchronous palette LUT between a fixed
//            latency video reader (absolute priority) and a host port.
//            Macro CGA_LUT_HOST_RD_EN adds host readback; without it a host
//            read is acknowledged without touching the RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cga_lut_arbiter
    import cga_lut_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STALL_MAX = DEF_STALL_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall_err
);

    lut_state_t         r_state;
    logic               r_host_ack;
    logic [VID_LAT-1:0] r_vid_pipe;
    logic [DATA_W-1:0]  r_vid_data;
    logic               w_idle;
    logic               w_grant;
    logic               w_stall_inc;

    // Host is only considered in IDLE and only when video leaves the RAM free;
    // reset masks requests so nothing is granted while it is held.
    assign w_idle      = (r_state == IDLE);
    assign w_grant     = w_idle && host_req && !vid_req && !reset;
    assign w_stall_inc = w_idle && host_req &&  vid_req && !reset;

    // RAM port: video wins the address; writes happen only on a host grant
    assign ram_addr  = vid_req ? vid_addr : host_addr;
    assign ram_we    = w_grant && host_we;
    assign ram_wdata = host_wdata;

    // Video pipe: stage 0 marks the cycle where RAM data returns, last stage qualifies vid_data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vid_pipe <= '0;
            r_vid_data <= '0;
        end else begin
            r_vid_pipe <= {r_vid_pipe[VID_LAT-2:0], vid_req};
            if (r_vid_pipe[VID_LAT-2]) begin
                r_vid_data <= ram_rdata;
            end
        end
    end

    assign vid_valid = r_vid_pipe[VID_LAT-1];
    assign vid_data  = r_vid_data;

`ifdef CGA_LUT_HOST_RD_EN
    logic [DATA_W-1:0] r_host_rdata;

    // Host FSM: writes ack one cycle after grant, reads capture RAM data one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
        end else begin
            r_host_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        if (host_we) begin
                            r_state    <= ACK;
                            r_host_ack <= 1'b1;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    r_state      <= RD_CAP;
                    r_host_ack   <= 1'b1;
                    r_host_rdata <= ram_rdata;
                end
                RD_CAP:  r_state <= IDLE;
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign host_rdata = r_host_rdata;
`else
    // Host FSM: every granted access, read or write, acks one cycle after grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_host_ack <= 1'b0;
        end else begin
            r_host_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state    <= ACK;
                        r_host_ack <= 1'b1;
                    end
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign host_rdata = '0;
`endif

    assign host_ack = r_host_ack;

    cga_lut_stall_mon #(
        .STALL_MAX (STALL_MAX)
    ) u_stall_mon (
        .clk         (clk),
        .rst         (reset),
        .i_inc       (w_stall_inc),
        .i_clr       (w_grant),
        .o_stall_err (stall_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_cga_lut_arbiter.sv
// ============================================================================
// Module   : tb_cga_lut_arbiter
// Brief    : Directed bench for cga_lut_arbiter with a behavioural LUT RAM.
//            Expectations follow CGA_LUT_HOST_RD_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cga_lut_arbiter;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 18;
    localparam int STALL_MAX = 15;
`ifdef CGA_LUT_HOST_RD_EN
    localparam bit c_RD_EN = 1'b1;
`else
    localparam bit c_RD_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              stall_err;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int we_cnt;
    int ack_cnt;
    int wr_cyc;

    typedef struct {
        logic              vreq;
        logic [ADDR_W-1:0] vaddr;
        logic              hreq;
        logic              hwe;
        logic [ADDR_W-1:0] haddr;
        logic [DATA_W-1:0] hwd;
        logic [ADDR_W-1:0] e_addr;
        logic              e_we;
    } vec_t;

    vec_t tbl [6];

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-first, one cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    cga_lut_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STALL_MAX (STALL_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .vid_valid  (vid_valid),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .stall_err  (stall_err)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        vid_req  = 1'b0;
        host_req = 1'b0;
        host_we  = 1'b0;
    endtask

    // Granted host write from IDLE with video quiet; fixed one-cycle ack
    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        vid_req    = 1'b0;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        #1;
        check("wr_ram_we", ram_we, 1);
        tick();
        check("wr_ack", host_ack, 1);
        check("wr_we_once", ram_we, 0);
        host_req = 1'b0;
        host_we  = 1'b0;
        tick();
        check("wr_ack_drop", host_ack, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 18'h00000, 16'h1234, 1'b0};
        tbl[1] = '{1'b1, 16'h1234, 1'b1, 1'b1, 16'h0042, 18'h15555, 16'h1234, 1'b0};
        tbl[2] = '{1'b0, 16'h1234, 1'b1, 1'b1, 16'h0100, 18'h0ABCD, 16'h0100, 1'b1};
        tbl[3] = '{1'b0, 16'h1234, 1'b1, 1'b0, 16'h0200, 18'h00000, 16'h0200, 1'b0};
        tbl[4] = '{1'b0, 16'h1234, 1'b0, 1'b1, 16'h0300, 18'h12345, 16'h0300, 1'b0};
        tbl[5] = '{1'b0, 16'hAAAA, 1'b1, 1'b1, 16'hFFFF, 18'h3FFFF, 16'hFFFF, 1'b1};

        // Reset state, with requests present that must be ignored
        reset = 1'b1; idle_inputs();
        vid_addr = '0; host_addr = '0; host_wdata = '0;
        repeat (3) @(negedge clk);
        vid_req = 1'b1; vid_addr = 16'h1234;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 18'h00001;
        #1;
        check("rst_ram_we", ram_we, 0);
        tick();
        check("rst_vid_valid", vid_valid, 0);
        check("rst_host_ack", host_ack, 0);
        check("rst_vid_data", vid_data, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_stall_err", stall_err, 0);
        reset = 1'b0; idle_inputs();
        tick();
        check("rst_no_late_ack", host_ack, 0);
        tick();
        check("rst_vid_ignored", vid_valid, 0);

        // Table: RAM port mux and ack in the following cycle
        for (int i = 0; i < 6; i++) begin
            vid_req    = tbl[i].vreq;
            vid_addr   = tbl[i].vaddr;
            host_req   = tbl[i].hreq;
            host_we    = tbl[i].hwe;
            host_addr  = tbl[i].haddr;
            host_wdata = tbl[i].hwd;
            #1;
            check($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].e_we);
            if (tbl[i].e_we) check($sformatf("tbl%0d_ram_wdata", i), ram_wdata, tbl[i].hwd);
            tick();
            idle_inputs();
            check($sformatf("tbl%0d_ack", i), host_ack,
                  tbl[i].hreq && !tbl[i].vreq && (tbl[i].hwe || !c_RD_EN));
            repeat (3) tick();
        end

        // Video lookup latency of exactly two cycles
        host_write(16'h1234, 18'h2A5A5);
        host_write(16'h1235, 18'h01111);
        host_write(16'h1236, 18'h3C3C3);
        vid_req = 1'b1; vid_addr = 16'h1234;
        tick();
        vid_req = 1'b0;
        check("vid_n1_valid", vid_valid, 0);
        tick();
        check("vid_n2_valid", vid_valid, 1);
        check("vid_n2_data", vid_data, 18'h2A5A5);
        tick();
        check("vid_n3_valid", vid_valid, 0);

        // Back-to-back video lookups
        vid_req = 1'b1; vid_addr = 16'h1234;
        tick();
        vid_addr = 16'h1235;
        tick();
        vid_addr = 16'h1236;
        check("b2b0_valid", vid_valid, 1);
        check("b2b0_data", vid_data, 18'h2A5A5);
        tick();
        vid_req = 1'b0;
        check("b2b1_valid", vid_valid, 1);
        check("b2b1_data", vid_data, 18'h01111);
        tick();
        check("b2b2_valid", vid_valid, 1);
        check("b2b2_data", vid_data, 18'h3C3C3);
        tick();
        check("b2b_end_valid", vid_valid, 0);

        // Host write then read back of the same entry
        host_write(16'h0042, 18'h3FFFF);
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0042;
        #1;
        check("rd_ram_we", ram_we, 0);
        tick();
`ifdef CGA_LUT_HOST_RD_EN
        check("rd_g1_ack", host_ack, 0);
        tick();
        check("rd_g2_ack", host_ack, 1);
        check("rd_g2_data", host_rdata, 18'h3FFFF);
`else
        check("rd_nomac_ack", host_ack, 1);
        check("rd_nomac_data", host_rdata, 0);
`endif
        host_req = 1'b0;
        tick();
        check("rd_ack_drop", host_ack, 0);

`ifdef CGA_LUT_HOST_RD_EN
        // Video issued while the host read waits in RD_WAIT
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0100;
        tick();
        vid_req = 1'b1; vid_addr = 16'h1234;
        tick();
        vid_req = 1'b0;
        check("rdv_host_ack", host_ack, 1);
        check("rdv_host_data", host_rdata, 18'h0ABCD);
        host_req = 1'b0;
        tick();
        check("rdv_vid_valid", vid_valid, 1);
        check("rdv_vid_data", vid_data, 18'h2A5A5);
        check("rdv_ack_drop", host_ack, 0);
        tick();
`endif

        // Held host write across video cycles 1,1,0: one write, one ack
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0055; host_wdata = 18'h2222A;
        vid_addr = 16'h1234; we_cnt = 0; ack_cnt = 0; wr_cyc = -1;
        for (int c = 0; c < 8; c++) begin
            vid_req = (c < 2);
            #1;
            if (ram_we) begin
                we_cnt++;
                wr_cyc = c;
            end
            tick();
            if (host_ack) begin
                ack_cnt++;
                host_req = 1'b0;
                host_we  = 1'b0;
            end
        end
        check("arb_we_count", we_cnt, 1);
        check("arb_we_cycle", wr_cyc, 2);
        check("arb_ack_count", ack_cnt, 1);
        idle_inputs();

        // Starvation flag after 15 denied cycles, sticky after service
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stall_clear", stall_err, 0);
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0077; host_wdata = 18'h00001;
        vid_req = 1'b1; we_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (ram_we) we_cnt++;
            tick();
        end
        check("stall_at14", stall_err, 0);
        #1;
        if (ram_we) we_cnt++;
        tick();
        check("stall_at15", stall_err, 1);
        check("stall_no_write", we_cnt, 0);
        vid_req = 1'b0;
        #1;
        check("stall_grant_we", ram_we, 1);
        tick();
        check("stall_grant_ack", host_ack, 1);
        idle_inputs();
        repeat (2) tick();
        check("stall_sticky", stall_err, 1);

        // Reset aborting an access, and suppressing an in-flight video pulse
`ifdef CGA_LUT_HOST_RD_EN
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0042;
        tick();
        reset = 1'b1; host_req = 1'b0;
        tick();
        check("abort_ack", host_ack, 0);
        check("abort_rdata", host_rdata, 0);
        check("abort_stall", stall_err, 0);
        reset = 1'b0;
        tick();
        check("abort_late_ack", host_ack, 0);
        tick();
        check("abort_idle_ack", host_ack, 0);
`else
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0042;
        #1;
        check("nomac_rd_we", ram_we, 0);
        tick();
        check("nomac_rd_ack", host_ack, 1);
        check("nomac_rd_data", host_rdata, 0);
        host_req = 1'b0;
        tick();
        check("nomac_rd_ack_drop", host_ack, 0);
`endif
        vid_req = 1'b1; vid_addr = 16'h1234;
        tick();
        vid_req = 1'b0; reset = 1'b1;
        tick();
        check("rst_inflight_valid", vid_valid, 0);
        check("rst_inflight_data", vid_data, 0);
        reset = 1'b0;
        tick();
        check("rst_after_valid", vid_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cga_lut_arbiter.md
CGA_LUT_ARBITER -- requirements
Module: cga_lut_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, composite pattern LUT address width.
REQ-002 The block SHALL have parameter DATA_W, default 18, LUT entry width (blue[17:12], green[11:6], red[5:0]).
REQ-003 The block SHALL have parameter STALL_MAX, default 15, the denied-host-cycle count that sets stall_err.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 The block SHALL have port vid_req, input, 1, one-cycle video lookup strobe.
REQ-007 The block SHALL have port vid_addr, input, ADDR_W, the pattern index, valid with vid_req.
REQ-008 The block SHALL have port vid_data, output, DATA_W, the registered colour for the video pipe.
REQ-009 The block SHALL have port vid_valid, output, 1, a one-cycle pulse qualifying vid_data.
REQ-010 The block SHALL have ports host_req (input, 1), host_we (input, 1), host_addr (input, ADDR_W) and host_wdata (input, DATA_W); together they form the host request, held stable until host_ack.
REQ-011 The block SHALL have ports host_ack (output, 1), the one-cycle completion pulse, and host_rdata (output, DATA_W), the read result, valid with host_ack.
REQ-012 The block SHALL have ports ram_addr (output, ADDR_W), ram_we (output, 1), ram_wdata (output, DATA_W) and ram_rdata (input, DATA_W); these drive the single-port synchronous LUT RAM, which returns read data one cycle after the address.
REQ-013 The block SHALL have port stall_err, output, 1, sticky host starvation flag.

Function
REQ-014 The block SHALL drive the RAM port combinationally: vid_req=1 selects vid_addr with ram_we=0; otherwise a granted host access selects host_addr and host_wdata, with ram_we=host_we.
REQ-015 Video SHALL have absolute priority, and video latency SHALL be fixed at 2: vid_req in cycle N gives vid_valid=1 and vid_data=ram_rdata(N+1) in cycle N+2.
REQ-016 vid_req in consecutive cycles SHALL be accepted back-to-back, with each request producing its own vid_valid at N+2.
REQ-017 The FSM SHALL have states IDLE, RD_WAIT, RD_CAP and ACK.
REQ-018 The host SHALL be granted in the cycle where state=IDLE, host_req=1 and vid_req=0.
REQ-019 A granted write SHALL go IDLE->ACK, with host_ack=1 in the next cycle.
REQ-020 A granted read SHALL go IDLE->RD_WAIT->RD_CAP; host_rdata SHALL be registered from ram_rdata and host_ack=1 in RD_CAP (grant+2), then the FSM SHALL return to IDLE.
REQ-021 ACK and RD_CAP SHALL be non-grant cycles, so a held host_req is never serviced twice; the next grant is possible at the earliest one cycle later.
REQ-022 While the FSM is in RD_WAIT, vid_req SHALL still be issued to the RAM, because the RAM is pipelined.
REQ-023 A stall counter SHALL increment on each cycle with host_req=1, state=IDLE and vid_req=1; it SHALL clear on grant and saturate at STALL_MAX.
REQ-024 When the stall counter reaches STALL_MAX, stall_err SHALL be set and held until reset; video priority SHALL be unchanged.
REQ-025 host_req=0 in IDLE SHALL leave the RAM idle, with ram_we=0 and ram_addr=host_addr.

Reset
REQ-026 While reset=1: FSM=IDLE, vid_valid=0, host_ack=0, ram_we=0, vid_data=0, host_rdata=0, stall counter=0, stall_err=0.
REQ-027 A reset asserted mid-read or mid-write SHALL abort the access with no host_ack pulse.
REQ-028 During reset, vid_valid pulses already in flight SHALL be suppressed.
REQ-029 Requests SHALL be ignored during reset and sampled from the first cycle after deassertion.

Configuration
REQ-030 Macro CGA_LUT_HOST_RD_EN, when defined, SHALL provide host readback as specified in REQ-020.
REQ-031 When CGA_LUT_HOST_RD_EN is undefined, a host read SHALL issue no RAM access, go IDLE->ACK, ack the next cycle, and keep host_rdata at 0; RD_WAIT and RD_CAP SHALL be absent.

Structure
REQ-032 Package cga_lut_pkg SHALL hold the FSM state enum, the default ADDR_W/DATA_W/STALL_MAX constants, and the latency constants VID_LAT=2 and HOST_RD_LAT=2.
REQ-033 Sub-module cga_lut_stall_mon SHALL implement the saturating stall counter and the sticky stall_err flag.

Verification
REQ-034 Reset release, vid_req with vid_addr=16'h1234 and ram model entry 18'h2A5A5 -> vid_valid and vid_data=18'h2A5A5 exactly 2 cycles later.
REQ-035 Host write 16'h0042/18'h3FFFF while vid_req=0 -> ram_we=1 for one cycle, host_ack 1 cycle later, then a host read of 16'h0042 -> host_rdata=18'h3FFFF at grant+2 (macro defined).
REQ-036 host_req held while vid_req toggles 1,1,0 -> grant in the third cycle, with no RAM write in cycles 1-2 and exactly one host_ack.
REQ-037 vid_req held high for 15 cycles with host_req=1 -> stall_err=1 after the 15th denied cycle and stays 1 after the host is later served.
REQ-038 reset asserted in RD_WAIT -> no host_ack, FSM=IDLE, all outputs 0; a read with the macro undefined -> ack after 1 cycle, host_rdata=0, no RAM access.
